carregador_programa: RTL

Program loader that fills the processor's unified instruction/data memory from an external byte stream before the pipeline runs. It is the write side of the memory the fetch stage reads. It receives a framed byte stream (word count, big-endian instruction words, checksum) over a valid/ready handshake and issues one-cycle word writes to the memory write port. It holds the processor stalled until a load completes with a valid checksum.

---
 rtl/carregador_programa.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/carregador_programa.sv
// Program loader: receives a framed byte stream (count, big-endian words, XOR checksum)
// and writes each word into the unified instruction/data memory, stalling the CPU until done.
module carregador_programa #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              iniciar,
  input  logic [7:0]        byteEntrada,
  input  logic              byteValido,
  output logic              byteAceito,
  output logic [ADDR_W-1:0] enderecoMem,
  output logic [31:0]       dadoMem,
  output logic              escreveMem,
  output logic              segurarCPU,
  output logic              carregado,
  output logic              erroCarga
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    CNT_H    = 3'd1,
    CNT_L    = 3'd2,
    DADOS    = 3'd3,
    ESCREVE  = 3'd4,
    CHECKSUM = 3'd5,
    FIM      = 3'd6,
    ERRO     = 3'd7
  } estado_t;

  // Largest count that fits the memory; 17 bits so 2^16 is representable.
  localparam logic [16:0] LIMITE_N = 17'd1 << ADDR_W;

  estado_t           r_estado;
  estado_t           w_prox;
  logic [15:0]       r_n;
  logic [15:0]       r_idx;
  logic [1:0]        r_bidx;
  logic [7:0]        r_acc;
  logic [23:0]       r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic              r_aceito;
  logic              r_escreve;
  logic              r_segurar;
  logic              r_carregado;
  logic              r_erro;
  logic [15:0]       w_n_rx;
  logic [15:0]       w_idx_inc;

  assign w_n_rx    = {r_n[15:8], byteEntrada};
  assign w_idx_inc = r_idx + 16'd1;

  // Next-state decision
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO, FIM, ERRO: begin
        if (iniciar) w_prox = CNT_H;
        else         w_prox = r_estado;
      end
      CNT_H: begin
        if (byteValido) w_prox = CNT_L;
        else            w_prox = r_estado;
      end
      CNT_L: begin
        if (!byteValido)                   w_prox = r_estado;
        else if ({1'b0, w_n_rx} > LIMITE_N) w_prox = ERRO;
        else if (w_n_rx == 16'd0)          w_prox = CHECKSUM;
        else                               w_prox = DADOS;
      end
      DADOS: begin
        if (byteValido && (r_bidx == 2'd3)) w_prox = ESCREVE;
        else                                w_prox = r_estado;
      end
      ESCREVE: begin
        if (w_idx_inc == r_n) w_prox = CHECKSUM;
        else                  w_prox = DADOS;
      end
      CHECKSUM: begin
        if (!byteValido)                w_prox = r_estado;
        else if (byteEntrada == r_acc) w_prox = FIM;
        else                            w_prox = ERRO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  // State, datapath and outputs registered from the next state
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_estado    <= OCIOSO;
      r_n         <= 16'd0;
      r_idx       <= 16'd0;
      r_bidx      <= 2'd0;
      r_acc       <= 8'd0;
      r_word      <= 24'd0;
      r_addr      <= {ADDR_W{1'b0}};
      r_data      <= 32'd0;
      r_aceito    <= 1'b0;
      r_escreve   <= 1'b0;
      r_segurar   <= 1'b1;
      r_carregado <= 1'b0;
      r_erro      <= 1'b0;
    end else begin
      r_estado    <= w_prox;
      r_aceito    <= (w_prox == CNT_H) || (w_prox == CNT_L) ||
                     (w_prox == DADOS) || (w_prox == CHECKSUM);
      r_escreve   <= (w_prox == ESCREVE);
      r_segurar   <= (w_prox != FIM);
      r_carregado <= (w_prox == FIM);
      r_erro      <= (w_prox == ERRO);
      case (r_estado)
        OCIOSO, FIM, ERRO: begin
          if (iniciar) begin
            r_idx  <= 16'd0;
            r_bidx <= 2'd0;
            r_acc  <= 8'd0;
          end
        end
        CNT_H: begin
          if (byteValido) begin
            r_n[15:8] <= byteEntrada;
            r_acc     <= r_acc ^ byteEntrada;
          end
        end
        CNT_L: begin
          if (byteValido) begin
            r_n[7:0] <= byteEntrada;
            r_acc    <= r_acc ^ byteEntrada;
          end
        end
        DADOS: begin
          if (byteValido) begin
            r_word <= {r_word[15:0], byteEntrada};
            r_acc  <= r_acc ^ byteEntrada;
            r_bidx <= r_bidx + 2'd1;
            // Address/data are latched here so they are stable for the whole ESCREVE cycle.
            if (r_bidx == 2'd3) begin
              r_addr <= BASE_ADDR + r_idx[ADDR_W-1:0];
              r_data <= {r_word, byteEntrada};
            end
          end
        end
        ESCREVE: r_idx <= w_idx_inc;
        default: ;
      endcase
    end
  end

  assign byteAceito  = r_aceito;
  assign enderecoMem = r_addr;
  assign dadoMem     = r_data;
  assign escreveMem  = r_escreve;
  assign segurarCPU  = r_segurar;
  assign carregado   = r_carregado;
  assign erroCarga   = r_erro;

endmodule
